// File: rtl/btn_led_ctrl.sv
// Button-to-LED controller: synchronises and debounces BTN1, classifies presses
// as short or long, and steps a four-mode LED state machine (OFF/ON/SLOW/FAST).
module btn_led_ctrl #(
  parameter bit BTN_ACTIVE_LOW = 1'b0,
  parameter int DEBOUNCE_CYC   = 120000,
  parameter int LONG_CYC       = 12000000,
  parameter int SLOW_HALF_CYC  = 6000000,
  parameter int FAST_HALF_CYC  = 1500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  output logic       LED1,
  output logic [1:0] MODE,
  output logic       PRESS_SHORT,
  output logic       PRESS_LONG
);

  localparam int DEB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W   = $clog2(LONG_CYC + 1);
  localparam int HALF_MAX = (SLOW_HALF_CYC > FAST_HALF_CYC) ? SLOW_HALF_CYC : FAST_HALF_CYC;
  localparam int BLINK_W  = $clog2(HALF_MAX + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF_CYC - 1);
  localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF_CYC - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  logic [1:0]         r_sync;
  logic               r_btn_d;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_long_fired;
  logic               r_press_short;
  logic               r_press_long;
  mode_t              r_mode;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;
  logic               r_led;

  logic               w_btn_s;
  logic               w_deb_flip;
  logic [BLINK_W-1:0] w_half_last;

  // The synchroniser resets to the released pad level so an idle button
  // never looks like a press while the flops refill after reset.
  assign w_btn_s     = r_sync[1] ^ BTN_ACTIVE_LOW;
  assign w_deb_flip  = (w_btn_s != r_btn_d) && (r_deb_cnt == DEB_LAST);
  assign w_half_last = (r_mode == MODE_FAST) ? FAST_LAST : SLOW_LAST;

  // Debouncer and press classifier. The short pulse is issued on the same
  // edge that drops btn_d; a release on that edge suppresses any long pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync        <= {2{BTN_ACTIVE_LOW}};
      r_btn_d       <= 1'b0;
      r_deb_cnt     <= '0;
      r_hold_cnt    <= '0;
      r_long_fired  <= 1'b0;
      r_press_short <= 1'b0;
      r_press_long  <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], BTN1};
      r_press_short <= 1'b0;
      r_press_long  <= 1'b0;

      if (w_btn_s == r_btn_d) begin
        r_deb_cnt <= '0;
      end else if (w_deb_flip) begin
        r_deb_cnt <= '0;
        r_btn_d   <= w_btn_s;
        if (w_btn_s) begin
          r_hold_cnt   <= '0;
          r_long_fired <= 1'b0;
        end else begin
          r_press_short <= ~r_long_fired;
        end
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end

      if (r_btn_d && !w_deb_flip) begin
        if (r_hold_cnt != HOLD_MAX) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        if ((r_hold_cnt == HOLD_LAST) && !r_long_fired) begin
          r_press_long <= 1'b1;
          r_long_fired <= 1'b1;
        end
      end
    end
  end

  // Mode FSM and LED generator; every mode change restarts the blink lit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode      <= MODE_OFF;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
      r_led       <= 1'b0;
    end else begin
      case (r_mode)
        MODE_OFF: r_led <= 1'b0;
        MODE_ON:  r_led <= 1'b1;
        default:  r_led <= r_blink;
      endcase

      if (r_press_long && (r_mode != MODE_OFF)) begin
        r_mode      <= MODE_OFF;
        r_blink_cnt <= '0;
        r_blink     <= 1'b1;
      end else if (r_press_short) begin
        r_mode      <= mode_t'(r_mode + 2'd1);
        r_blink_cnt <= '0;
        r_blink     <= 1'b1;
      end else if ((r_mode == MODE_SLOW) || (r_mode == MODE_FAST)) begin
        if (r_blink_cnt == w_half_last) begin
          r_blink_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign LED1        = r_led;
  assign MODE        = r_mode;
  assign PRESS_SHORT = r_press_short;
  assign PRESS_LONG  = r_press_long;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with small timing parameters: one active-high
// button instance and one active-low instance sharing the clock.
module tb_btn_led_ctrl;

  logic       clk = 1'b0;
  logic       rst, btn, led, ps, pl;
  logic [1:0] mode;
  logic       rst_al, btn_al, led_al, ps_al, pl_al;
  logic [1:0] mode_al;

  int n_checks = 0;
  int n_errs   = 0;
  int short_cnt = 0, long_cnt = 0, both_cnt = 0;
  int short_al  = 0, long_al  = 0;

  always #5 clk = ~clk;

  btn_led_ctrl #(
    .BTN_ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(4), .LONG_CYC(40),
    .SLOW_HALF_CYC(8), .FAST_HALF_CYC(2)
  ) dut (
    .CLK(clk), .RST(rst), .BTN1(btn), .LED1(led), .MODE(mode),
    .PRESS_SHORT(ps), .PRESS_LONG(pl)
  );

  btn_led_ctrl #(
    .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .LONG_CYC(40),
    .SLOW_HALF_CYC(8), .FAST_HALF_CYC(2)
  ) dut_al (
    .CLK(clk), .RST(rst_al), .BTN1(btn_al), .LED1(led_al), .MODE(mode_al),
    .PRESS_SHORT(ps_al), .PRESS_LONG(pl_al)
  );

  // Pulse monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (ps === 1'b1) short_cnt++;
    if (pl === 1'b1) long_cnt++;
    if ((ps === 1'b1) && (pl === 1'b1)) both_cnt++;
    if (ps_al === 1'b1) short_al++;
    if (pl_al === 1'b1) long_al++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    btn = 1'b1;
    step(n);
    btn = 1'b0;
  endtask

  task automatic press_al(input int n);
    btn_al = 1'b0;
    step(n);
    btn_al = 1'b1;
  endtask

  task automatic test_reset();
    int s0, l0;
    rst = 1'b1; btn = 1'b1;
    step(3);
    n_checks++; if (led !== 1'b0) begin n_errs++; $display("FAIL reset_led: got %b expected 0", led); end
    n_checks++; if (mode !== 2'd0) begin n_errs++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    n_checks++; if (ps !== 1'b0) begin n_errs++; $display("FAIL reset_short: got %b expected 0", ps); end
    n_checks++; if (pl !== 1'b0) begin n_errs++; $display("FAIL reset_long: got %b expected 0", pl); end
    s0 = short_cnt; l0 = long_cnt;
    rst = 1'b0;
    step(10);
    btn = 1'b0;
    step(5);
    n_checks++; if (ps !== 1'b0) begin n_errs++; $display("FAIL held_short_early: got %b expected 0", ps); end
    step(1);
    n_checks++; if (ps !== 1'b1) begin n_errs++; $display("FAIL held_short_pulse: got %b expected 1", ps); end
    step(1);
    n_checks++; if (ps !== 1'b0) begin n_errs++; $display("FAIL held_short_width: got %b expected 0", ps); end
    n_checks++; if (mode !== 2'd1) begin n_errs++; $display("FAIL held_mode: got %0d expected 1", mode); end
    step(1);
    n_checks++; if (led !== 1'b1) begin n_errs++; $display("FAIL held_led_on: got %b expected 1", led); end
    n_checks++; if (short_cnt - s0 !== 1) begin n_errs++; $display("FAIL held_short_count: got %0d expected 1", short_cnt - s0); end
    n_checks++; if (long_cnt - l0 !== 0) begin n_errs++; $display("FAIL held_long_count: got %0d expected 0", long_cnt - l0); end
  endtask

  task automatic test_short_press_slow_blink();
    press(10);
    step(5);
    n_checks++; if (ps !== 1'b0) begin n_errs++; $display("FAIL short_early: got %b expected 0", ps); end
    step(1);
    n_checks++; if (ps !== 1'b1) begin n_errs++; $display("FAIL short_pulse: got %b expected 1", ps); end
    step(1);
    n_checks++; if (mode !== 2'd2) begin n_errs++; $display("FAIL short_mode_slow: got %0d expected 2", mode); end
    step(1);
    n_checks++; if (led !== 1'b1) begin n_errs++; $display("FAIL slow_start_lit: got %b expected 1", led); end
    step(7);
    n_checks++; if (led !== 1'b1) begin n_errs++; $display("FAIL slow_last_lit: got %b expected 1", led); end
    step(1);
    n_checks++; if (led !== 1'b0) begin n_errs++; $display("FAIL slow_first_dark: got %b expected 0", led); end
    step(7);
    n_checks++; if (led !== 1'b0) begin n_errs++; $display("FAIL slow_last_dark: got %b expected 0", led); end
    step(1);
    n_checks++; if (led !== 1'b1) begin n_errs++; $display("FAIL slow_relit: got %b expected 1", led); end
  endtask

  task automatic test_long_press();
    int s0, l0;
    s0 = short_cnt; l0 = long_cnt;
    btn = 1'b1;
    step(45);
    n_checks++; if (pl !== 1'b0) begin n_errs++; $display("FAIL long_early: got %b expected 0", pl); end
    step(1);
    n_checks++; if (pl !== 1'b1) begin n_errs++; $display("FAIL long_pulse: got %b expected 1", pl); end
    step(1);
    n_checks++; if (pl !== 1'b0) begin n_errs++; $display("FAIL long_width: got %b expected 0", pl); end
    n_checks++; if (mode !== 2'd0) begin n_errs++; $display("FAIL long_mode_off: got %0d expected 0", mode); end
    step(13);
    btn = 1'b0;
    step(10);
    n_checks++; if (led !== 1'b0) begin n_errs++; $display("FAIL long_led_off: got %b expected 0", led); end
    n_checks++; if (short_cnt - s0 !== 0) begin n_errs++; $display("FAIL long_no_short: got %0d expected 0", short_cnt - s0); end
    n_checks++; if (long_cnt - l0 !== 1) begin n_errs++; $display("FAIL long_count: got %0d expected 1", long_cnt - l0); end
  endtask

  task automatic test_mode_cycle();
    logic [4:0] fast_pat;
    logic [1:0] exp_mode;
    fast_pat = 5'b10011;  // LED at M+1..M+5 is bit 0..4: 1,1,0,0,1
    for (int i = 1; i <= 4; i++) begin
      exp_mode = 2'(i % 4);
      press(10);
      step(7);
      n_checks++; if (mode !== exp_mode) begin n_errs++; $display("FAIL cycle_mode_%0d: got %0d expected %0d", i, mode, exp_mode); end
      if (i == 3) begin
        for (int j = 0; j < 5; j++) begin
          step(1);
          n_checks++; if (led !== fast_pat[j]) begin n_errs++; $display("FAIL fast_led_%0d: got %b expected %b", j, led, fast_pat[j]); end
        end
      end
      if (i == 4) begin
        step(1);
        n_checks++; if (led !== 1'b0) begin n_errs++; $display("FAIL cycle_off_led: got %b expected 0", led); end
      end
    end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = short_cnt;
    btn = 1'b1; step(1); btn = 1'b0; step(1);
    btn = 1'b1; step(1); btn = 1'b0; step(20);
    n_checks++; if (mode !== 2'd0) begin n_errs++; $display("FAIL bounce_mode: got %0d expected 0", mode); end
    btn = 1'b1; step(3); btn = 1'b0; step(20);
    n_checks++; if (short_cnt - s0 !== 0) begin n_errs++; $display("FAIL glitch_no_pulse: got %0d expected 0", short_cnt - s0); end
    btn = 1'b1; step(4); btn = 1'b0; step(6);
    n_checks++; if (ps !== 1'b1) begin n_errs++; $display("FAIL min_press_pulse: got %b expected 1", ps); end
    step(1);
    n_checks++; if (mode !== 2'd1) begin n_errs++; $display("FAIL min_press_mode: got %0d expected 1", mode); end
  endtask

  task automatic test_reset_mid_press();
    int s0, l0;
    s0 = short_cnt; l0 = long_cnt;
    btn = 1'b1;
    step(30);
    rst = 1'b1;
    step(2);
    n_checks++; if (mode !== 2'd0) begin n_errs++; $display("FAIL midrst_mode: got %0d expected 0", mode); end
    rst = 1'b0;
    step(30);
    btn = 1'b0;
    step(10);
    n_checks++; if (long_cnt - l0 !== 0) begin n_errs++; $display("FAIL midrst_no_long: got %0d expected 0", long_cnt - l0); end
    n_checks++; if (short_cnt - s0 !== 1) begin n_errs++; $display("FAIL midrst_short: got %0d expected 1", short_cnt - s0); end
    n_checks++; if (mode !== 2'd1) begin n_errs++; $display("FAIL midrst_mode_after: got %0d expected 1", mode); end
  endtask

  task automatic test_active_low();
    btn_al = 1'b1;
    step(1);
    rst_al = 1'b0;
    step(8);
    n_checks++; if (short_al !== 0) begin n_errs++; $display("FAIL al_idle_no_press: got %0d expected 0", short_al); end
    press_al(10);
    step(5);
    n_checks++; if (ps_al !== 1'b0) begin n_errs++; $display("FAIL al_short_early: got %b expected 0", ps_al); end
    step(1);
    n_checks++; if (ps_al !== 1'b1) begin n_errs++; $display("FAIL al_short_pulse: got %b expected 1", ps_al); end
    step(1);
    n_checks++; if (mode_al !== 2'd1) begin n_errs++; $display("FAIL al_mode_on: got %0d expected 1", mode_al); end
    step(1);
    n_checks++; if (led_al !== 1'b1) begin n_errs++; $display("FAIL al_led_on: got %b expected 1", led_al); end
    press_al(10); step(10);
    press_al(10); step(10);
    n_checks++; if (mode_al !== 2'd3) begin n_errs++; $display("FAIL al_mode_fast: got %0d expected 3", mode_al); end
    step(3);
    rst_al = 1'b1;
    step(1);
    n_checks++; if (led_al !== 1'b0) begin n_errs++; $display("FAIL al_rst_led: got %b expected 0", led_al); end
    n_checks++; if (mode_al !== 2'd0) begin n_errs++; $display("FAIL al_rst_mode: got %0d expected 0", mode_al); end
    rst_al = 1'b0;
    step(8);
    n_checks++; if (mode_al !== 2'd0) begin n_errs++; $display("FAIL al_post_rst_mode: got %0d expected 0", mode_al); end
    n_checks++; if (short_al !== 3) begin n_errs++; $display("FAIL al_short_count: got %0d expected 3", short_al); end
    n_checks++; if (long_al !== 0) begin n_errs++; $display("FAIL al_long_count: got %0d expected 0", long_al); end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0;
    rst_al = 1'b1; btn_al = 1'b1;
    test_reset();
    test_short_press_slow_blink();
    test_long_press();
    test_mode_cycle();
    test_bounce();
    test_reset_mid_press();
    test_active_low();
    n_checks++; if (both_cnt !== 0) begin n_errs++; $display("FAIL pulses_overlap: got %0d expected 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
